// File: rtl/gbus_pkg.sv
// rtl/gbus_pkg.sv - shared gbus receive widths, beat derivation and FSM state type
package gbus_pkg;

  localparam int GBUS_DATA_WIDTH_DEF      = 128;
  localparam int GBUS_ADDR_WIDTH_DEF      = 14;
  localparam int INTERFACE_DATA_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF           = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rx_state_e;

  function automatic int calc_beats(input int gbus_w, input int intf_w);
    return gbus_w / intf_w;
  endfunction

  // A single-word beat still needs a one-bit index port.
  function automatic int calc_beat_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/gbus_rx_fifo.sv
// rtl/gbus_rx_fifo.sv - register-array FIFO with zero-latency head and wrap-bit pointers
module gbus_rx_fifo #(
  parameter int WIDTH = 142,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/gbus_rx_serializer.sv
// rtl/gbus_rx_serializer.sv - buffers gbus write beats and serializes them onto the host port
module gbus_rx_serializer
  import gbus_pkg::*;
#(
  parameter int GBUS_DATA_WIDTH      = GBUS_DATA_WIDTH_DEF,
  parameter int GBUS_ADDR_WIDTH      = GBUS_ADDR_WIDTH_DEF,
  parameter int INTERFACE_DATA_WIDTH = INTERFACE_DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH           = FIFO_DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_gbus_wen,
  input  logic [GBUS_ADDR_WIDTH-1:0]       in_gbus_addr,
  input  logic [GBUS_DATA_WIDTH-1:0]       in_gbus_wdata,
  output logic                             host_vld,
  input  logic                             host_rdy,
  output logic [INTERFACE_DATA_WIDTH-1:0]  host_data,
  output logic [GBUS_ADDR_WIDTH-1:0]       host_addr,
  output logic [calc_beat_idx_w(calc_beats(GBUS_DATA_WIDTH, INTERFACE_DATA_WIDTH))-1:0] host_beat,
  output logic                             host_last,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_cnt,
  output logic                             overflow,
  input  logic                             overflow_clr,
  output logic                             busy
);

  localparam int BEATS      = calc_beats(GBUS_DATA_WIDTH, INTERFACE_DATA_WIDTH);
  localparam int BEAT_IDX_W = calc_beat_idx_w(BEATS);
  localparam int ENTRY_W    = GBUS_ADDR_WIDTH + GBUS_DATA_WIDTH;
  localparam logic [BEAT_IDX_W-1:0] LAST_IDX = BEAT_IDX_W'(BEATS - 1);

  rx_state_e                  state_q;
  rx_state_e                  state_d;
  logic [GBUS_DATA_WIDTH-1:0] shift_q;
  logic [GBUS_ADDR_WIDTH-1:0] addr_q;
  logic [BEAT_IDX_W-1:0]      idx_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic               handshake;
  logic               at_last;

  assign handshake = (state_q == SEND) && host_rdy;
  assign at_last   = (idx_q == LAST_IDX);
  // Popping on the last handshake chains beats with no idle cycle between them.
  assign fifo_pop  = !fifo_empty && ((state_q == IDLE) || (handshake && at_last));
  assign fifo_push = in_gbus_wen && (!fifo_full || fifo_pop);

  gbus_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({in_gbus_addr, in_gbus_wdata}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = SEND;
      SEND:    if (handshake && at_last && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    host_vld  = (state_q == SEND);
    host_last = (state_q == SEND) && at_last;
    host_beat = idx_q;
    host_data = shift_q[INTERFACE_DATA_WIDTH-1:0];
    host_addr = addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
    end else if (fifo_pop) begin
      shift_q <= fifo_head[GBUS_DATA_WIDTH-1:0];
      addr_q  <= fifo_head[ENTRY_W-1:GBUS_DATA_WIDTH];
      idx_q   <= '0;
    end else if (handshake && !at_last) begin
      shift_q <= shift_q >> INTERFACE_DATA_WIDTH;
      idx_q   <= idx_q + 1'b1;
    end
  end

  // A new drop outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                                   overflow <= 1'b0;
    else if (in_gbus_wen && !fifo_push)        overflow <= 1'b1;
    else if (overflow_clr)                     overflow <= 1'b0;
  end

  assign busy = (fifo_cnt != '0) || (state_q == SEND);

endmodule

// File: tb/tb_gbus_rx_serializer.sv
// tb/tb_gbus_rx_serializer.sv - scoreboard bench for gbus_rx_serializer
module tb_gbus_rx_serializer;

  localparam int GW    = 128;
  localparam int AW    = 14;
  localparam int IW    = 16;
  localparam int DEPTH = 8;
  localparam int BEATS = GW / IW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_gbus_wen = 1'b0;
  logic [AW-1:0] in_gbus_addr = '0;
  logic [GW-1:0] in_gbus_wdata = '0;
  logic          host_vld;
  logic          host_rdy = 1'b0;
  logic [IW-1:0] host_data;
  logic [AW-1:0] host_addr;
  logic [2:0]    host_beat;
  logic          host_last;
  logic [3:0]    fifo_cnt;
  logic          overflow;
  logic          overflow_clr = 1'b0;
  logic          busy;

  gbus_rx_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .in_gbus_wen   (in_gbus_wen),
    .in_gbus_addr  (in_gbus_addr),
    .in_gbus_wdata (in_gbus_wdata),
    .host_vld      (host_vld),
    .host_rdy      (host_rdy),
    .host_data     (host_data),
    .host_addr     (host_addr),
    .host_beat     (host_beat),
    .host_last     (host_last),
    .fifo_cnt      (fifo_cnt),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [GW-1:0] data;
  } beat_t;

  typedef struct {
    logic [IW-1:0] data;
    logic [AW-1:0] addr;
    int            idx;
    logic          last;
  } word_t;

  beat_t m_fifo[$];
  word_t exp_q[$];
  bit    m_active = 0;
  int    m_left = 0;
  bit    m_ovf = 0;
  int    errors = 0;
  int    checks = 0;
  int    hs_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pending-beat queue plus words left in the beat being sent.
  always @(posedge clk) begin : model
    bit    hs;
    bit    pop;
    bit    accept;
    beat_t b;
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_active = 0;
      m_left   = 0;
      m_ovf    = 0;
    end else begin
      hs     = m_active && host_rdy;
      pop    = (m_fifo.size() > 0) && (!m_active || (hs && m_left == 1));
      accept = in_gbus_wen && ((m_fifo.size() < DEPTH) || pop);
      if (in_gbus_wen && !accept) m_ovf = 1;
      else if (overflow_clr)      m_ovf = 0;
      if (hs) m_left--;
      if (pop) begin
        b = m_fifo.pop_front();
        m_active = 1;
        m_left   = BEATS;
        for (int i = 0; i < BEATS; i++)
          exp_q.push_back('{data: b.data[i*IW +: IW], addr: b.addr, idx: i, last: (i == BEATS-1)});
      end else if (hs && m_left == 0) begin
        m_active = 0;
      end
      if (accept) m_fifo.push_back('{addr: in_gbus_addr, data: in_gbus_wdata});
    end
  end

  bit            prev_stall = 0;
  logic [IW-1:0] prev_data;
  logic [AW-1:0] prev_addr;
  logic [2:0]    prev_beat;
  logic          prev_last;

  always @(negedge clk) begin : monitor
    word_t w;
    if (rst) begin
      prev_stall = 0;
    end else begin
      chk("host_vld", host_vld, m_active);
      chk("fifo_cnt", fifo_cnt, m_fifo.size());
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, m_active || (m_fifo.size() != 0));
      if (prev_stall) begin
        chk("stall_vld", host_vld, 1'b1);
        chk("stall_data", host_data, prev_data);
        chk("stall_addr", host_addr, prev_addr);
        chk("stall_beat", host_beat, prev_beat);
        chk("stall_last", host_last, prev_last);
      end
      if (host_vld && host_rdy) begin
        hs_cnt++;
        chk("word_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("word_data", host_data, w.data);
          chk("word_addr", host_addr, w.addr);
          chk("word_beat", host_beat, w.idx[2:0]);
          chk("word_last", host_last, w.last);
        end
      end
      prev_stall = host_vld && !host_rdy;
      prev_data  = host_data;
      prev_addr  = host_addr;
      prev_beat  = host_beat;
      prev_last  = host_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_beat(input logic [AW-1:0] a);
    in_gbus_addr = a;
    for (int i = 0; i < GW / 32; i++) in_gbus_wdata[i*32 +: 32] = $urandom;
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_gbus_wen = 0;
    host_rdy    = 1;
    while (busy && n < 500) begin
      step();
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  initial begin
    int run;
    int maxrun;
    int hs0;

    step();
    step();
    chk("rst_vld", host_vld, 1'b0);
    chk("rst_data", host_data, 16'h0);
    chk("rst_addr", host_addr, 14'h0);
    chk("rst_beat", host_beat, 3'h0);
    chk("rst_last", host_last, 1'b0);
    chk("rst_cnt", fifo_cnt, 4'h0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 0;
    step();

    // Single beat: byte i = i, latency and word order.
    host_rdy = 1;
    for (int i = 0; i < 16; i++) in_gbus_wdata[i*8 +: 8] = 8'(i);
    in_gbus_addr = 14'h12A;
    in_gbus_wen  = 1;
    step();
    in_gbus_wen = 0;
    chk("lat_k", host_vld, 1'b0);
    step();
    chk("lat_k1", host_vld, 1'b1);
    chk("first_data", host_data, 16'h0100);
    chk("first_addr", host_addr, 14'h12A);
    chk("first_last", host_last, 1'b0);
    for (int j = 1; j < BEATS; j++) step();
    chk("final_data", host_data, 16'h0F0E);
    chk("final_last", host_last, 1'b1);
    chk("final_beat", host_beat, 3'd7);
    step();
    chk("single_busy", busy, 1'b0);

    // Back-to-back: three beats on consecutive cycles, one unbroken word run.
    run = 0;
    maxrun = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 3) begin
        in_gbus_wen = 1;
        set_beat(14'(14'h200 + c));
      end else begin
        in_gbus_wen = 0;
      end
      step();
      if (host_vld) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
    end
    chk("b2b_run", maxrun, 24);
    chk("b2b_ovf", overflow, 1'b0);

    // Backpressure: ready pattern 1,0,0.
    hs0 = hs_cnt;
    in_gbus_wen = 1;
    set_beat(14'h055);
    step();
    in_gbus_wen = 0;
    for (int c = 0; c < 40; c++) begin
      host_rdy = (c % 3 == 0);
      step();
    end
    drain("bp_drain");
    chk("bp_words", hs_cnt - hs0, BEATS);

    // Overflow: ten beats with the host stalled.
    host_rdy = 0;
    for (int c = 0; c < 10; c++) begin
      in_gbus_wen = 1;
      set_beat(14'(14'h300 + c));
      step();
    end
    in_gbus_wen = 0;
    chk("ovf_cnt", fifo_cnt, 4'd8);
    chk("ovf_set", overflow, 1'b1);
    overflow_clr = 1;
    step();
    overflow_clr = 0;
    chk("ovf_clr", overflow, 1'b0);
    host_rdy = 1;
    repeat (BEATS - 1) step();
    in_gbus_wen = 1;
    set_beat(14'h3FF);
    step();
    in_gbus_wen = 0;
    host_rdy    = 0;
    chk("full_pop_cnt", fifo_cnt, 4'd8);
    chk("full_pop_ovf", overflow, 1'b0);
    drain("ovf_drain");

    // Reset after four words with two beats queued.
    host_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      in_gbus_wen = 1;
      set_beat(14'(14'h0A0 + c));
      step();
    end
    in_gbus_wen = 0;
    host_rdy = 1;
    repeat (4) step();
    rst = 1;
    step();
    rst = 0;
    chk("mrst_vld", host_vld, 1'b0);
    chk("mrst_data", host_data, 16'h0);
    chk("mrst_addr", host_addr, 14'h0);
    chk("mrst_beat", host_beat, 3'h0);
    chk("mrst_cnt", fifo_cnt, 4'h0);
    chk("mrst_busy", busy, 1'b0);
    hs0 = hs_cnt;
    repeat (20) step();
    chk("mrst_silent", hs_cnt - hs0, 0);

    // Randomized traffic, stalls and overflow clears.
    for (int c = 0; c < 3000; c++) begin
      in_gbus_wen  = ($urandom_range(0, 3) == 0);
      host_rdy     = ($urandom_range(0, 2) != 0);
      overflow_clr = ($urandom_range(0, 19) == 0);
      set_beat(14'($urandom));
      step();
    end
    overflow_clr = 0;
    drain("rand_drain");
    chk("rand_all_words", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
